// File: rtl/iic_slave_regs.sv
// I2C target with a simple register port. The first write byte after the address
// sets the register pointer; later write bytes and all read bytes go through the
// port with pointer auto-increment. Open-drain SDA: Sda_O is always 0 and Sda_T
// releases (1) or pulls low (0).
module iic_slave_regs #(
  parameter logic [6:0]  SLAVE_ADDR = 7'h4C,
  parameter int unsigned FILT_LEN   = 3      // must be >= 2
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Scl_I,
  input  logic       Sda_I,
  output logic       Sda_O,
  output logic       Sda_T,
  output logic [7:0] Reg_Addr,
  output logic [7:0] Reg_WrData,
  output logic       Reg_WrEn,
  output logic       Reg_RdEn,
  input  logic [7:0] Reg_RdData,
  output logic       Busy
);

  typedef enum logic [2:0] {
    StIdle, StAddr, StAddrAck, StWrByte, StWrAck, StRdByte, StRdAck, StIgnore
  } state_e;

  state_e state_q, state_d;

  // Input conditioning
  logic [1:0]          scl_sync_q, sda_sync_q;
  logic [FILT_LEN-1:0] scl_hist_q, sda_hist_q;
  logic                scl_f_q, sda_f_q, scl_p_q, sda_p_q;

  // Datapath
  logic [7:0] shift_q, shift_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic       rw_q, rw_d;
  logic       ptr_q, ptr_d;       // next write byte is the register pointer
  logic       busy_q, busy_d;
  logic       sda_t_q, sda_t_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wrdata_q, wrdata_d;
  logic       wren_q, wren_d;
  logic       rden_q, rden_d;
  logic       rd_load_q;          // Reg_RdData is valid this cycle

  logic       scl_rise, scl_fall, start_det, stop_det, addr_match;
  logic [7:0] byte_in;

  // Synchronize both pads and accept a level only after FILT_LEN equal samples
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_hist_q <= '1;
      sda_hist_q <= '1;
      scl_f_q    <= 1'b1;
      sda_f_q    <= 1'b1;
      scl_p_q    <= 1'b1;
      sda_p_q    <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], Scl_I};
      sda_sync_q <= {sda_sync_q[0], Sda_I};
      scl_hist_q <= {scl_hist_q[FILT_LEN-2:0], scl_sync_q[1]};
      sda_hist_q <= {sda_hist_q[FILT_LEN-2:0], sda_sync_q[1]};
      if (&scl_hist_q) begin
        scl_f_q <= 1'b1;
      end else if (~|scl_hist_q) begin
        scl_f_q <= 1'b0;
      end
      if (&sda_hist_q) begin
        sda_f_q <= 1'b1;
      end else if (~|sda_hist_q) begin
        sda_f_q <= 1'b0;
      end
      scl_p_q <= scl_f_q;
      sda_p_q <= sda_f_q;
    end
  end

  assign scl_rise   = scl_f_q & ~scl_p_q;
  assign scl_fall   = ~scl_f_q & scl_p_q;
  assign start_det  = scl_f_q & scl_p_q & sda_p_q & ~sda_f_q;
  assign stop_det   = scl_f_q & scl_p_q & ~sda_p_q & sda_f_q;
  assign byte_in    = {shift_q[6:0], sda_f_q};
  assign addr_match = (byte_in[7:1] == SLAVE_ADDR);

  // State register
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; START/STOP override every state
  always_comb begin
    state_d = state_q;
    if (start_det) begin
      state_d = StAddr;
    end else if (stop_det) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StAddr:    if (scl_rise && bit_cnt_q == 4'd7) state_d = addr_match ? StAddrAck : StIgnore;
        StAddrAck: if (scl_rise) state_d = rw_q ? StRdByte : StWrByte;
        StWrByte:  if (scl_rise && bit_cnt_q == 4'd7) state_d = StWrAck;
        StWrAck:   if (scl_rise) state_d = StWrByte;
        StRdByte:  if (scl_fall && bit_cnt_q == 4'd8) state_d = StRdAck;
        StRdAck:   if (scl_rise) state_d = sda_f_q ? StIgnore : StRdByte;
        default:   ;
      endcase
    end
  end

  // Output and datapath next-state; SDA drive only changes after a SCL fall
  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    rw_d      = rw_q;
    ptr_d     = ptr_q;
    busy_d    = busy_q;
    sda_t_d   = sda_t_q;
    addr_d    = addr_q;
    wrdata_d  = wrdata_q;
    wren_d    = 1'b0;
    rden_d    = 1'b0;
    // Pointer advances the cycle after a write strobe
    if (wren_q) addr_d = addr_q + 8'd1;
    if (rd_load_q) shift_d = Reg_RdData;
    if (start_det) begin
      bit_cnt_d = 4'd0;
      sda_t_d   = 1'b1;
      busy_d    = 1'b0;
    end else if (stop_det) begin
      sda_t_d = 1'b1;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        StAddr: begin
          if (scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = 4'd0;
              if (addr_match) begin
                busy_d = 1'b1;
                rw_d   = byte_in[0];
              end
            end
          end
        end
        StAddrAck: begin
          if (scl_fall) sda_t_d = 1'b0;
          if (scl_rise) begin
            bit_cnt_d = 4'd0;
            if (rw_q) rden_d = 1'b1;
            else      ptr_d  = 1'b1;
          end
        end
        StWrByte: begin
          if (scl_fall) sda_t_d = 1'b1;
          if (scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = 4'd0;
              if (ptr_q) begin
                addr_d = byte_in;
                ptr_d  = 1'b0;
              end else begin
                wrdata_d = byte_in;
                wren_d   = 1'b1;
              end
            end
          end
        end
        StWrAck: begin
          if (scl_fall) sda_t_d = 1'b0;
        end
        StRdByte: begin
          // Fall 0 ends the ACK clock; falls 0..7 present bits, fall 8 releases
          if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_t_d   = 1'b1;
              bit_cnt_d = 4'd0;
            end else begin
              sda_t_d   = shift_q[7];
              shift_d   = {shift_q[6:0], 1'b1};
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        StRdAck: begin
          if (scl_rise) begin
            addr_d = addr_q + 8'd1;
            if (!sda_f_q) rden_d = 1'b1;
            else          busy_d = 1'b0;
          end
        end
        default: begin
          sda_t_d = 1'b1;
        end
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      shift_q   <= 8'h00;
      bit_cnt_q <= 4'd0;
      rw_q      <= 1'b0;
      ptr_q     <= 1'b0;
      busy_q    <= 1'b0;
      sda_t_q   <= 1'b1;
      addr_q    <= 8'h00;
      wrdata_q  <= 8'h00;
      wren_q    <= 1'b0;
      rden_q    <= 1'b0;
      rd_load_q <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      rw_q      <= rw_d;
      ptr_q     <= ptr_d;
      busy_q    <= busy_d;
      sda_t_q   <= sda_t_d;
      addr_q    <= addr_d;
      wrdata_q  <= wrdata_d;
      wren_q    <= wren_d;
      rden_q    <= rden_d;
      rd_load_q <= rden_q;
    end
  end

  assign Sda_O      = 1'b0;
  assign Sda_T      = sda_t_q;
  assign Reg_Addr   = addr_q;
  assign Reg_WrData = wrdata_q;
  assign Reg_WrEn   = wren_q;
  assign Reg_RdEn   = rden_q;
  assign Busy       = busy_q;

endmodule

// File: tb/tb_iic_slave_regs.sv
// Bench for iic_slave_regs: a bit-banged I2C master plus a transaction-level
// model of the register pointer and expected register-port events.
module tb_iic_slave_regs;

  localparam int Q = 10;  // quarter SCL period in Clk cycles

  logic       Clk = 1'b0;
  logic       Rst;
  logic       Scl_I;
  logic       Sda_I;
  logic       Sda_O;
  logic       Sda_T;
  logic [7:0] Reg_Addr;
  logic [7:0] Reg_WrData;
  logic       Reg_WrEn;
  logic       Reg_RdEn;
  logic [7:0] Reg_RdData;
  logic       Busy;

  logic m_sda;
  logic glitch;
  logic sda_line;

  iic_slave_regs #(.SLAVE_ADDR(7'h4C), .FILT_LEN(3)) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .Scl_I      (Scl_I),
    .Sda_I      (Sda_I),
    .Sda_O      (Sda_O),
    .Sda_T      (Sda_T),
    .Reg_Addr   (Reg_Addr),
    .Reg_WrData (Reg_WrData),
    .Reg_WrEn   (Reg_WrEn),
    .Reg_RdEn   (Reg_RdEn),
    .Reg_RdData (Reg_RdData),
    .Busy       (Busy)
  );

  always #5 Clk = ~Clk;

  // Wired-AND open-drain bus
  assign sda_line   = m_sda & (Sda_T | Sda_O);
  assign Sda_I      = sda_line & ~glitch;
  assign Reg_RdData = Reg_Addr ^ 8'h5A;

  int checks = 0;
  int errors = 0;

  // Model state
  logic [15:0] exp_wr[$];
  logic [7:0]  exp_rd[$];
  logic [7:0]  m_addr   = 8'h00;
  logic        m_active = 1'b0;
  logic        m_ptr    = 1'b0;
  int          low_cnt  = 0;
  logic        sda_t_prev = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask

  // Per-cycle compare against the model's expected register-port events
  always @(negedge Clk) begin
    if (Rst) begin
      sda_t_prev <= 1'b1;
    end else begin
      if (!Sda_T) low_cnt <= low_cnt + 1;
      if (sda_t_prev && !Sda_T) chk("drive_start_scl_low", Scl_I, 1'b0);
      sda_t_prev <= Sda_T;
      chk("sda_o", Sda_O, 1'b0);
      if (Reg_WrEn) begin
        if (exp_wr.size() == 0) begin
          chk("unexpected_wren", {Reg_Addr, Reg_WrData}, 32'hFFFF_FFFF);
        end else begin
          logic [15:0] e;
          e = exp_wr.pop_front();
          chk("wr_addr", Reg_Addr, e[15:8]);
          chk("wr_data", Reg_WrData, e[7:0]);
        end
      end
      if (Reg_RdEn) begin
        if (exp_rd.size() == 0) begin
          chk("unexpected_rden", Reg_Addr, 32'hFFFF_FFFF);
        end else begin
          logic [7:0] a;
          a = exp_rd.pop_front();
          chk("rd_addr", Reg_Addr, a);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic bit_x(input logic b, input logic glt, output logic r);
    m_sda = b;
    cyc(Q);
    Scl_I = 1'b1;
    cyc(Q);
    if (glt) begin
      glitch = 1'b1;
      cyc(1);
      glitch = 1'b0;
    end
    r = sda_line;
    cyc(Q);
    Scl_I = 1'b0;
    cyc(Q);
  endtask

  task automatic do_start();
    m_sda = 1'b1;
    cyc(Q);
    Scl_I = 1'b1;
    cyc(Q);
    m_sda = 1'b0;
    cyc(Q);
    Scl_I = 1'b0;
    cyc(Q);
    m_active = 1'b0;
    m_ptr    = 1'b0;
  endtask

  task automatic do_stop();
    m_sda = 1'b0;
    cyc(Q);
    Scl_I = 1'b1;
    cyc(Q);
    m_sda = 1'b1;
    cyc(2 * Q);
    m_active = 1'b0;
    chk("busy_after_stop", Busy, 1'b0);
  endtask

  // glt_bit selects a bit index to glitch (8 = none); returns the 9th-bit level
  task automatic wr_byte(input logic [7:0] b, input int glt_bit, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_x(b[i], (i == glt_bit), r);
    bit_x(1'b1, 1'b0, ack);
  endtask

  task automatic tx_addr(input logic [7:0] b);
    logic ack, match;
    match = (b[7:1] == 7'h4C);
    if (match && b[0]) exp_rd.push_back(m_addr);
    wr_byte(b, 8, ack);
    chk("addr_ack", ack, !match);
    chk("busy_after_addr", Busy, match);
    m_active = match;
    m_ptr    = match && !b[0];
  endtask

  task automatic tx_data(input logic [7:0] b, input int glt_bit);
    logic ack;
    logic act;
    act = m_active;
    if (m_active) begin
      if (m_ptr) begin
        m_addr = b;
        m_ptr  = 1'b0;
      end else begin
        exp_wr.push_back({m_addr, b});
        m_addr = m_addr + 8'd1;
      end
    end
    wr_byte(b, glt_bit, ack);
    chk("data_ack", ack, !act);
  endtask

  task automatic rx_data(input logic mack, output logic [7:0] d);
    logic [7:0] e;
    logic r;
    e      = m_addr ^ 8'h5A;
    m_addr = m_addr + 8'd1;
    if (!mack) exp_rd.push_back(m_addr);
    for (int i = 7; i >= 0; i--) bit_x(1'b1, 1'b0, d[i]);
    bit_x(mack, 1'b0, r);
    chk("rd_byte_model", d, e);
    if (mack) m_active = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    logic       ack;
    int         low0;

    Rst = 1'b1; Scl_I = 1'b1; m_sda = 1'b1; glitch = 1'b0;
    cyc(5);
    chk("rst_sda_t", Sda_T, 1'b1);
    chk("rst_sda_o", Sda_O, 1'b0);
    chk("rst_reg_addr", Reg_Addr, 8'h00);
    chk("rst_wrdata", Reg_WrData, 8'h00);
    chk("rst_wren", Reg_WrEn, 1'b0);
    chk("rst_rden", Reg_RdEn, 1'b0);
    chk("rst_busy", Busy, 1'b0);
    Rst = 1'b0;
    cyc(2 * Q);

    // Pointer write then two data bytes
    do_start();
    tx_addr(8'h98);
    tx_data(8'h10, 8);
    tx_data(8'hAB, 8);
    tx_data(8'hCD, 8);
    do_stop();
    chk("t1_reg_addr", Reg_Addr, 8'h12);
    chk("t1_reg_addr_model", Reg_Addr, m_addr);

    // Set pointer, repeated START, read three bytes
    do_start();
    tx_addr(8'h98);
    tx_data(8'h20, 8);
    do_start();
    tx_addr(8'h99);
    rx_data(1'b0, d);
    chk("t2_rd0", d, 8'h7A);
    rx_data(1'b0, d);
    chk("t2_rd1", d, 8'h7B);
    rx_data(1'b1, d);
    chk("t2_rd2", d, 8'h78);
    chk("t2_sda_t_nack", Sda_T, 1'b1);
    chk("t2_busy_nack", Busy, 1'b0);
    chk("t2_reg_addr", Reg_Addr, 8'h23);
    do_stop();

    // Address mismatch: never drive SDA
    low0 = low_cnt;
    do_start();
    tx_addr(8'h9A);
    tx_data(8'h11, 8);
    tx_data(8'h22, 8);
    do_stop();
    chk("t3_sda_low_cycles", low_cnt - low0, 0);
    chk("t3_reg_addr", Reg_Addr, 8'h23);

    // Pointer wrap
    do_start();
    tx_addr(8'h98);
    tx_data(8'hFF, 8);
    tx_data(8'h11, 8);
    tx_data(8'h22, 8);
    do_stop();
    chk("t4_reg_addr_wrap", Reg_Addr, 8'h01);

    // Glitch in IDLE, then a byte with no START must not be ACKed
    glitch = 1'b1;
    cyc(1);
    glitch = 1'b0;
    cyc(2 * Q);
    chk("t5_busy_idle", Busy, 1'b0);
    Scl_I = 1'b0;
    cyc(Q);
    wr_byte(8'h98, 8, ack);
    chk("t5_no_start_ack", ack, 1'b1);
    m_sda = 1'b1;
    Scl_I = 1'b1;
    cyc(2 * Q);
    // Glitch low during a '1' data bit
    do_start();
    tx_addr(8'h98);
    tx_data(8'h40, 8);
    tx_data(8'hFF, 4);
    chk("t5_wrdata_glitch", Reg_WrData, 8'hFF);
    do_stop();
    chk("t5_reg_addr", Reg_Addr, 8'h41);

    // Reset while the target is driving a 0 data bit
    do_start();
    tx_addr(8'h99);
    chk("t6_driving_low", Sda_T, 1'b0);
    Rst = 1'b1;
    #1;
    chk("t6_async_release", Sda_T, 1'b1);
    chk("t6_rst_reg_addr", Reg_Addr, 8'h00);
    chk("t6_rst_busy", Busy, 1'b0);
    chk("t6_rst_wren", Reg_WrEn, 1'b0);
    chk("t6_rst_rden", Reg_RdEn, 1'b0);
    chk("t6_rst_wrdata", Reg_WrData, 8'h00);
    m_addr = 8'h00; m_active = 1'b0; m_ptr = 1'b0;
    m_sda = 1'b1;
    Scl_I = 1'b1;
    cyc(3);
    Rst = 1'b0;
    cyc(2 * Q);
    do_start();
    tx_addr(8'h98);
    tx_data(8'h05, 8);
    tx_data(8'h77, 8);
    do_stop();
    chk("t6_reg_addr", Reg_Addr, 8'h06);

    chk("wr_events_left", exp_wr.size(), 0);
    chk("rd_events_left", exp_rd.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/iic_slave_regs.md
Name: iic_slave_regs

Overview:
- I2C target (responder) for bench/loopback use against the ROACH IIC master path; sits on the far side of the open-drain SDA/SCL tri-state pads.
- Decodes START/STOP, matches a 7-bit address, and ACKs.
- Write transfers: first data byte is a register pointer; later bytes write through a simple register port.
- Read transfers: return bytes fetched through the same port, with pointer auto-increment.

Parameters:
SLAVE_ADDR, 7'h4C, 7-bit target address matched after START.
FILT_LEN, 3, consecutive equal synchronized samples required before a SCL/SDA level change is accepted (glitch filter).

Ports:
Clk  input  1  system clock, ≥10x SCL rate.
Rst  input  1  asynchronous, active-high reset.
Scl_I  input  1  SCL pad input.
Sda_I  input  1  SDA pad input.
Sda_O  output  1  SDA output value; constant 0 (open drain).
Sda_T  output  1  SDA tri-state enable: 1 = released, 0 = drive low.
Reg_Addr  output  8  current register pointer.
Reg_WrData  output  8  received data byte.
Reg_WrEn  output  1  one-cycle write strobe for Reg_Addr/Reg_WrData.
Reg_RdEn  output  1  one-cycle read strobe; Reg_RdData is sampled exactly 1 cycle later.
Reg_RdData  input  8  read data for Reg_Addr.
Busy  output  1  high from address match until STOP/START/NACK release.

Behaviour:
- Reset values:
  - Sda_O=0, Sda_T=1, Reg_Addr=0, Reg_WrData=0, Reg_WrEn=0, Reg_RdEn=0, Busy=0.
  - Filters preset to 1; state IDLE.
- Input conditioning:
  - 2-flop synchronizer, then a FILT_LEN-sample filter on each line.
  - Edge/condition detects are 1-cycle pulses on filtered signals.
  - START = SDA fall while SCL high. STOP = SDA rise while SCL high.
- SDA handling:
  - Sampled on SCL rising edge.
  - Driven value (Sda_T) changes only on the cycle after a detected SCL falling edge.
- START (incl. repeated START) in any state: go to ADDR, bit counter=0, Sda_T=1. Reg_Addr is retained.
- STOP in any state: IDLE, Sda_T=1, Busy=0.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits MSB first. After 8th SCL rise:
    - If bits[7:1]==SLAVE_ADDR → ADDR_ACK; Busy=1; RW=bit0.
    - Otherwise → IGNORE.
  - ADDR_ACK: pull SDA low for the 9th clock; release after 9th SCL fall.
    - RW=0 → WR_BYTE; pointer-phase flag set.
    - RW=1 → Reg_RdEn pulse on 9th SCL rise, load shifter from Reg_RdData next cycle, then RD_BYTE.
  - WR_BYTE: shift 8 bits. After 8th SCL rise:
    - Pointer phase: Reg_Addr←byte; clear flag.
    - Otherwise: Reg_WrData←byte, Reg_WrEn pulse same cycle with current Reg_Addr, then Reg_Addr+1 next cycle.
    - Then → WR_ACK.
  - WR_ACK: ACK (SDA low) for 9th clock, then → WR_BYTE.
  - RD_BYTE: present shifter MSB on each SCL fall, including the fall ending the ACK clock. After 8th SCL fall: release SDA → RD_ACK.
  - RD_ACK: sample master bit on 9th SCL rise.
    - 0 (ACK): Reg_Addr+1, Reg_RdEn, reload, → RD_BYTE.
    - 1 (NACK): Reg_Addr+1, → IGNORE; Busy=0.
  - IGNORE: Sda_T=1; wait for START/STOP.
- Reg_Addr wraps 8'hFF→8'h00.
- Never drive SDA while SCL high except during ACK/data bits already set up at the preceding fall.
- Reset mid-transfer: immediate release (Sda_T=1), all outputs to reset values.

Test Plan:
- Write 0x98,0x10,0xAB,0xCD,STOP → ACK on all 4 bytes; WrEn at addr 0x10 data 0xAB, then addr 0x11 data 0xCD; final Reg_Addr=0x12; Busy=0 after STOP.
- Write 0x98,0x20, repeated START, 0x99, read 3 bytes (ACK,ACK,NACK) with Reg_RdData=addr^0x5A → SDA bits 0x7A,0x7B,0x78; RdEn at 0x20,0x21,0x22; Reg_Addr=0x23; Sda_T=1 after NACK.
- Address 0x9A (mismatch) + 2 bytes → Sda_T stays 1 throughout; no WrEn/RdEn; Busy=0.
- Pointer 0xFF, write 0x11,0x22 → writes at 0xFF then 0x00; Reg_Addr=0x01 (wrap).
- 1-cycle SDA glitch while SCL high in IDLE and during a data bit (FILT_LEN=3) → no START/STOP detected, byte value unaffected.
- Rst asserted during RD_BYTE with SDA held low → Sda_T=1 in the same cycle (async); after release, state IDLE and a fresh write to 0x98 is ACKed.
